// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between a set of four requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives the grant outputs).
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_new;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  gnt_new
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output gnt_new
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a bounded grant hold.
// The grant is registered; gnt_idx doubles as the downstream mux select.
// Priority rotates only when the holder lets go or is preempted. A holder that
// keeps requesting while others wait is cut off after MAX_HOLD cycles.
// MAX_HOLD = 0 disables the cut-off.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // With no hold limit the counter has nothing to compare against, so it parks at all-ones
    localparam logic [HOLD_W-1:0] CNT_CAP    = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] CNT_ONE    = HOLD_W'(1);
    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

    state_t            state, state_nxt;
    logic [1:0]        holder, holder_nxt;     // current owner; also the encoded grant index
    logic [1:0]        ptr, ptr_nxt;           // highest-priority requester for the next pick
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt; // cycles the current owner has held the grant
    logic [3:0]        gnt_q, gnt_nxt;
    logic              gnt_new_q, gnt_new_nxt;

    logic [3:0]        others;       // requests excluding the current holder
    logic [1:0]        after_h;      // slot just past the holder, wraps 3 -> 0
    logic              holder_req;
    logic              hold_expired;

    // First set bit of r scanning circularly from p: rotate so p lands at bit 0,
    // find the lowest set bit, then add p back (2-bit add wraps mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {r, r};
        rot = 4'(dbl >> p);
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        return p + off;
    endfunction

    // Holder-relative views of the request vector
    always_comb begin
        others       = bus.req & ~(4'b0001 << holder);
        after_h      = holder + 2'd1;
        holder_req   = bus.req[holder];
        hold_expired = PREEMPT_EN && (hold_cnt == CNT_CAP);
    end

    // Next-state, pointer, hold counter and next registered outputs
    always_comb begin
        state_nxt    = state;
        holder_nxt   = holder;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_new_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt    = GRANT;
                    holder_nxt   = rr_pick(bus.req, ptr);
                    hold_cnt_nxt = CNT_ONE;
                    gnt_new_nxt  = 1'b1;
                end
            end

            GRANT: begin
                if (!holder_req) begin
                    // Release: rotate past the holder and hand over on the same edge
                    ptr_nxt = after_h;
                    if (|bus.req) begin
                        holder_nxt   = rr_pick(bus.req, after_h);
                        hold_cnt_nxt = CNT_ONE;
                        gnt_new_nxt  = 1'b1;
                    end else begin
                        state_nxt    = IDLE;
                        holder_nxt   = 2'd0;
                        hold_cnt_nxt = '0;
                    end
                end else if (hold_expired && (|others)) begin
                    // Preempt: holder used its full slot and someone else is waiting
                    ptr_nxt      = after_h;
                    holder_nxt   = rr_pick(others, after_h);
                    hold_cnt_nxt = CNT_ONE;
                    gnt_new_nxt  = 1'b1;
                end else if (hold_cnt != CNT_CAP) begin
                    hold_cnt_nxt = hold_cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt    = IDLE;
                holder_nxt   = 2'd0;
                hold_cnt_nxt = '0;
            end
        endcase

        gnt_nxt = (state_nxt == GRANT) ? (4'b0001 << holder_nxt) : 4'b0000;
    end

    // State and registered outputs; reset drops any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            holder    <= 2'd0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt_q     <= 4'b0000;
            gnt_new_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            holder    <= holder_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt_q     <= gnt_nxt;
            gnt_new_q <= gnt_new_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = holder;
    assign bus.gnt_valid = (state == GRANT);
    assign bus.gnt_new   = gnt_new_q;

    // Grant stays one-hot or empty and always agrees with the encoded index
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_idx:    assert property (@(posedge clk) disable iff (!rst_n)
                               gnt_q == ((state == GRANT) ? (4'b0001 << holder) : 4'b0000));
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: two instances (hold limit 8 and unlimited) share one
// request stream. Every driven cycle pushes the reference model's expected outputs
// into a queue; a monitor pops and compares just after each rising edge.
module tb_rr_arbiter_4;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arbiter_4_if bus8();
    rr_arbiter_4_if bus0();

    rr_arbiter_4 #(.MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    rr_arbiter_4 #(.MAX_HOLD(0), .HOLD_W(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       nw;
    } out_t;

    // holder = -1 means nobody granted
    typedef struct {
        int holder;
        int ptr;
        int cnt;
    } mdl_t;

    typedef struct {
        out_t e8;
        out_t e0;
    } item_t;

    localparam int STARVE_MAX = 3 * 8 + 3;

    item_t sb_q[$];
    mdl_t  m8, m0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    wt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // First requester at or after p, circularly
    function automatic int scan(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock of the arbitration rules, applied to request vector r
    function automatic out_t step(input mdl_t si, output mdl_t so, input logic [3:0] r, input int mh);
        out_t       o;
        bit         fresh;
        logic [3:0] oth;
        so    = si;
        fresh = 1'b0;
        if (so.holder < 0) begin
            if (r != 4'b0) begin
                so.holder = scan(r, so.ptr);
                fresh = 1'b1;
            end
        end else if (!r[so.holder]) begin
            so.ptr    = (so.holder + 1) % 4;
            so.holder = scan(r, so.ptr);
            fresh     = (so.holder >= 0);
            if (!fresh) so.cnt = 0;
        end else begin
            oth = r;
            oth[so.holder] = 1'b0;
            if (mh != 0 && so.cnt == mh && oth != 4'b0) begin
                so.ptr    = (so.holder + 1) % 4;
                so.holder = scan(oth, so.ptr);
                fresh     = 1'b1;
            end else begin
                so.cnt++;
                if (mh != 0 && so.cnt > mh) so.cnt = mh;
            end
        end
        if (fresh) so.cnt = 1;
        o.gnt   = (so.holder >= 0) ? (4'b0001 << so.holder) : 4'b0000;
        o.idx   = (so.holder >= 0) ? 2'(so.holder) : 2'd0;
        o.valid = (so.holder >= 0);
        o.nw    = fresh;
        return o;
    endfunction

    task automatic model_reset();
        m8 = '{holder: -1, ptr: 0, cnt: 0};
        m0 = '{holder: -1, ptr: 0, cnt: 0};
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic drive(input logic [3:0] v);
        item_t it;
        mdl_t  t;
        bus8.req = v;
        bus0.req = v;
        it.e8 = step(m8, t, v, 8);
        m8 = t;
        it.e0 = step(m0, t, v, 0);
        m0 = t;
        sb_q.push_back(it);
        @(negedge clk);
    endtask

    task automatic expect8(input string nm, input logic [3:0] g, input logic [1:0] idx, input logic nw);
        chk({nm, "_gnt"},   32'(bus8.gnt),       32'(g));
        chk({nm, "_idx"},   32'(bus8.gnt_idx),   32'(idx));
        chk({nm, "_valid"}, 32'(bus8.gnt_valid), 32'(|g));
        chk({nm, "_new"},   32'(bus8.gnt_new),   32'(nw));
    endtask

    // Scoreboard monitor plus one-hot and starvation watch
    always @(posedge clk) begin
        item_t it;
        out_t  o8, o0;
        int    worst;
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) wt[i] = 0;
        end else if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            o8 = {bus8.gnt, bus8.gnt_idx, bus8.gnt_valid, bus8.gnt_new};
            o0 = {bus0.gnt, bus0.gnt_idx, bus0.gnt_valid, bus0.gnt_new};
            chk("sb_hold8", 32'(o8), 32'(it.e8));
            chk("sb_hold0", 32'(o0), 32'(it.e0));
            chk("onehot",   32'($onehot0(bus8.gnt)), 32'd1);
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus8.req[i] && !bus8.gnt[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > worst) worst = wt[i];
            end
            chk("starve_bound", 32'(worst <= STARVE_MAX), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        rst_n    = 1'b1;
        bus8.req = 4'b0;
        bus0.req = 4'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect8("reset_state", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Single requester from IDLE
        drive(4'b0010); expect8("single_grant",   4'b0010, 2'd1, 1'b1);
        drive(4'b0010); expect8("single_hold",    4'b0010, 2'd1, 1'b0);
        drive(4'b0000); expect8("single_release", 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset in the middle of a grant
        drive(4'b0100); expect8("pre_reset", 4'b0100, 2'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect8("async_reset", 4'b0000, 2'd0, 1'b0);
        chk("async_reset_gnt0", 32'(bus0.gnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation: each holder drops for one cycle right after being granted
        drive(4'b1111); expect8("rot0", 4'b0001, 2'd0, 1'b1);
        drive(4'b1110); expect8("rot1", 4'b0010, 2'd1, 1'b1);
        drive(4'b1101); expect8("rot2", 4'b0100, 2'd2, 1'b1);
        drive(4'b1011); expect8("rot3", 4'b1000, 2'd3, 1'b1);
        drive(4'b0111); expect8("rot4", 4'b0001, 2'd0, 1'b1);

        // Preemption after exactly 8 held cycles
        drive(4'b0000); expect8("pre_idle", 4'b0000, 2'd0, 1'b0);
        drive(4'b0001); expect8("hold_c1", 4'b0001, 2'd0, 1'b1);
        drive(4'b0001); expect8("hold_c2", 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(4'b0101); expect8("hold_cn", 4'b0001, 2'd0, 1'b0);
        end
        drive(4'b0101); expect8("preempt", 4'b0100, 2'd2, 1'b1);
        chk("no_limit_holds", 32'(bus0.gnt), 32'(4'b0001));

        // No contention: a lone requester keeps the grant
        drive(4'b0000);
        for (int i = 0; i < 20; i++) begin
            drive(4'b1000);
            expect8("lone_hold", 4'b1000, 2'd3, (i == 0));
        end
        drive(4'b0000);
        for (int i = 0; i < 12; i++) begin
            drive(4'b1001);
            chk("unlimited_hold", 32'(bus0.gnt), 32'(4'b0001));
        end

        // Handover skips past the releasing holder
        drive(4'b0000);
        drive(4'b0010); expect8("skip_setup", 4'b0010, 2'd1, 1'b1);
        drive(4'b0101); expect8("skip", 4'b0100, 2'd2, 1'b1);
        chk("skip_gnt0", 32'(bus0.gnt), 32'(4'b0100));

        // Random sweep: each request line toggles with probability 1/8 per cycle
        r = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            drive(r);
        end
        drive(4'b0000);

        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
